sw_max_tracker: RTL

- Pipelined, parametrised successor to the combinational max helpers.
- Each cycle it reduces LANES signed PE scores to a maximum and its lane index through a registered comparator tree.
- It accumulates the running maximum, lane and beat position across a framed stream, then emits one result per frame.
- It sits behind the systolic PE array and reports the best local-alignment score and its coordinates.

---
 rtl/sw_max_tracker_if.sv | 37 +++
 rtl/sw_max_tracker.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sw_max_tracker_if.sv
// sw_max_tracker_if
//   Beat/result bundle for sw_max_tracker.
//   i_valid/i_first/i_last : beat valid and frame delimiters
//   i_data                 : LANES signed scores, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_lane_en              : per-lane enable (0 = lane ignored)
//   o_valid                : one-cycle result pulse
//   o_max/o_lane/o_step    : frame maximum, its lane and its beat index
//   o_none                 : no enabled lane in the whole frame
//   o_step_sat             : beat counter saturated during the frame
//   master drives the beats (producer side), slave is the tracker.
interface sw_max_tracker_if #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 8,
    parameter int STEP_WIDTH = 16
);
    logic                          i_valid;
    logic                          i_first;
    logic                          i_last;
    logic [DATA_WIDTH*LANES-1:0]   i_data;
    logic [LANES-1:0]              i_lane_en;
    logic                          o_valid;
    logic [DATA_WIDTH-1:0]         o_max;
    logic [$clog2(LANES)-1:0]      o_lane;
    logic [STEP_WIDTH-1:0]         o_step;
    logic                          o_none;
    logic                          o_step_sat;

    modport master (
        output i_valid, i_first, i_last, i_data, i_lane_en,
        input  o_valid, o_max, o_lane, o_step, o_none, o_step_sat
    );

    modport slave (
        input  i_valid, i_first, i_last, i_data, i_lane_en,
        output o_valid, o_max, o_lane, o_step, o_none, o_step_sat
    );
endinterface

// File: rtl/sw_max_tracker.sv
// sw_max_tracker
//   Reduces LANES signed scores per beat to (max, lane) through a registered
//   comparator tree of log2(LANES) stages, then accumulates the best result
//   over a framed stream and emits one result per frame.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : sw_max_tracker_if.slave (beat inputs, result outputs)
module sw_max_tracker #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 8,
    parameter int STEP_WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    sw_max_tracker_if.slave bus
);
    localparam int L    = $clog2(LANES);
    localparam int IW   = L;
    localparam int NN   = LANES - 1;       // registered tree nodes
    localparam int NS   = 2 * LANES - 1;   // leaves + nodes
    localparam int ROOT = NS - 1;
    localparam logic signed [DATA_WIDTH-1:0] MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // Combined view: entries 0..LANES-1 are the masked input lanes, entries
    // LANES.. are the registered nodes, level by level (root last).
    logic signed [DATA_WIDTH-1:0] w_src_val  [NS];
    logic        [IW-1:0]         w_src_idx  [NS];
    logic                         w_src_none [NS];

    logic signed [DATA_WIDTH-1:0] r_node_val  [NN];
    logic        [IW-1:0]         r_node_idx  [NN];
    logic                         r_node_none [NN];
    logic signed [DATA_WIDTH-1:0] w_node_val  [NN];
    logic        [IW-1:0]         w_node_idx  [NN];
    logic                         w_node_none [NN];

    logic [L-1:0] r_vld, r_fst, r_lst;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_leaf
            assign w_src_none[gi] = ~bus.i_lane_en[gi];
            assign w_src_val[gi]  = bus.i_lane_en[gi] ? $signed(bus.i_data[gi*DATA_WIDTH +: DATA_WIDTH]) : MIN;
            assign w_src_idx[gi]  = IW'(gi);
        end
        for (gi = 0; gi < NN; gi++) begin : g_node
            assign w_src_val[LANES+gi]  = r_node_val[gi];
            assign w_src_idx[LANES+gi]  = r_node_idx[gi];
            assign w_src_none[LANES+gi] = r_node_none[gi];
        end
    endgenerate

    // Node j of level lv reads pair (2j, 2j+1) of level lv-1. The left operand
    // is always the lower lane range, so keeping it on ties favours low lanes,
    // unless it is a masked lane.
    always_comb begin
        int  s_idx;
        int  d_idx;
        logic a_win;
        s_idx = 0;
        d_idx = 0;
        a_win = 1'b0;
        for (int k = 0; k < NN; k++) begin
            w_node_val[k]  = '0;
            w_node_idx[k]  = '0;
            w_node_none[k] = 1'b0;
        end
        for (int lv = 1; lv <= L; lv++) begin
            for (int j = 0; j < (LANES >> lv); j++) begin
                s_idx = 2*LANES - 2*(LANES >> (lv-1)) + 2*j;
                d_idx = LANES - 2*(LANES >> lv) + j;
                a_win = (w_src_val[s_idx] > w_src_val[s_idx+1]) ||
                        ((w_src_val[s_idx] == w_src_val[s_idx+1]) && !w_src_none[s_idx]);
                w_node_val[d_idx]  = a_win ? w_src_val[s_idx] : w_src_val[s_idx+1];
                w_node_idx[d_idx]  = a_win ? w_src_idx[s_idx] : w_src_idx[s_idx+1];
                w_node_none[d_idx] = w_src_none[s_idx] & w_src_none[s_idx+1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NN; k++) begin
                r_node_val[k]  <= '0;
                r_node_idx[k]  <= '0;
                r_node_none[k] <= 1'b0;
            end
            r_vld <= '0;
            r_fst <= '0;
            r_lst <= '0;
        end else begin
            for (int k = 0; k < NN; k++) begin
                r_node_val[k]  <= w_node_val[k];
                r_node_idx[k]  <= w_node_idx[k];
                r_node_none[k] <= w_node_none[k];
            end
            // Frame flags travel with their beat through the tree.
            r_vld[0] <= bus.i_valid;
            r_fst[0] <= bus.i_valid & bus.i_first;
            r_lst[0] <= bus.i_valid & bus.i_last;
            for (int i = 1; i < L; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_fst[i] <= r_fst[i-1];
                r_lst[i] <= r_lst[i-1];
            end
        end
    end

    // ---------------- frame accumulator ----------------
    logic                         w_t_vld, w_t_fst, w_t_lst, w_t_none;
    logic signed [DATA_WIDTH-1:0] w_t_val;
    logic        [IW-1:0]         w_t_idx;

    assign w_t_vld  = r_vld[L-1];
    assign w_t_fst  = r_fst[L-1];
    assign w_t_lst  = r_lst[L-1];
    assign w_t_val  = w_src_val[ROOT];
    assign w_t_idx  = w_src_idx[ROOT];
    assign w_t_none = w_src_none[ROOT];

    logic                         r_in_frame, r_acc_none, r_sat;
    logic signed [DATA_WIDTH-1:0] r_acc_val;
    logic        [IW-1:0]         r_acc_idx;
    logic        [STEP_WIDTH-1:0] r_acc_step, r_cnt;
    logic                         w_in_frame_next, w_acc_none_next, w_sat_next, w_emit;
    logic signed [DATA_WIDTH-1:0] w_acc_val_next;
    logic        [IW-1:0]         w_acc_idx_next;
    logic        [STEP_WIDTH-1:0] w_acc_step_next, w_cnt_next;

    logic                         r_o_valid, r_o_none, r_o_sat;
    logic        [DATA_WIDTH-1:0] r_o_max;
    logic        [IW-1:0]         r_o_lane;
    logic        [STEP_WIDTH-1:0] r_o_step;

    always_comb begin
        w_in_frame_next = r_in_frame;
        w_acc_val_next  = r_acc_val;
        w_acc_idx_next  = r_acc_idx;
        w_acc_step_next = r_acc_step;
        w_acc_none_next = r_acc_none;
        w_cnt_next      = r_cnt;
        w_sat_next      = r_sat;
        w_emit          = 1'b0;
        if (w_t_vld) begin
            if (w_t_fst) begin
                // A first beat always (re)starts the frame.
                w_acc_val_next  = w_t_val;
                w_acc_idx_next  = w_t_none ? '0 : w_t_idx;
                w_acc_step_next = '0;
                w_acc_none_next = w_t_none;
                w_cnt_next      = '0;
                w_sat_next      = 1'b0;
                w_in_frame_next = 1'b1;
            end else if (r_in_frame) begin
                w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + STEP_WIDTH'(1);
                w_sat_next = r_sat | (&r_cnt);
                // Strict compare keeps the earliest beat on ties; a none beat
                // is MIN and can never win the strict compare.
                if ((w_t_val > r_acc_val) || (r_acc_none && !w_t_none)) begin
                    w_acc_val_next  = w_t_val;
                    w_acc_idx_next  = w_t_idx;
                    w_acc_step_next = w_cnt_next;
                    w_acc_none_next = 1'b0;
                end
            end
            if (w_t_lst && (w_t_fst || r_in_frame)) begin
                w_emit          = 1'b1;
                w_in_frame_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_frame <= 1'b0;
            r_acc_val  <= '0;
            r_acc_idx  <= '0;
            r_acc_step <= '0;
            r_acc_none <= 1'b0;
            r_cnt      <= '0;
            r_sat      <= 1'b0;
            r_o_valid  <= 1'b0;
            r_o_max    <= '0;
            r_o_lane   <= '0;
            r_o_step   <= '0;
            r_o_none   <= 1'b0;
            r_o_sat    <= 1'b0;
        end else begin
            r_in_frame <= w_in_frame_next;
            r_acc_val  <= w_acc_val_next;
            r_acc_idx  <= w_acc_idx_next;
            r_acc_step <= w_acc_step_next;
            r_acc_none <= w_acc_none_next;
            r_cnt      <= w_cnt_next;
            r_sat      <= w_sat_next;
            r_o_valid  <= w_emit;
            if (w_emit) begin
                r_o_max  <= w_acc_val_next;
                r_o_lane <= w_acc_idx_next;
                r_o_step <= w_acc_step_next;
                r_o_none <= w_acc_none_next;
                r_o_sat  <= w_sat_next;
            end
        end
    end

    assign bus.o_valid    = r_o_valid;
    assign bus.o_max      = r_o_max;
    assign bus.o_lane     = r_o_lane;
    assign bus.o_step     = r_o_step;
    assign bus.o_none     = r_o_none;
    assign bus.o_step_sat = r_o_sat;
endmodule
